// File: rtl/ps2_keyboard_rx_fifo.sv
// ps2_keyboard_rx_fifo
//   PS/2 keyboard receiver: 3-flop synchronisers, frame FSM (start, 8 data
//   bits LSB first, odd parity, stop), inter-edge timeout, E0/F0 prefix
//   decoding into 10-bit events {extended, break, code}, optional typematic
//   repeat filter, and an event FIFO drained with valid/ready.
//
//   Optional feature macro: PS2_PARITY_CHECK_EN
//     defined   - a parity mismatch is a frame error and the byte is dropped
//     undefined - the parity bit is captured but ignored
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   ps2_clk_in       raw PS/2 clock (asynchronous)
//   ps2_data_in      raw PS/2 data (asynchronous)
//   evt_valid        FIFO non-empty
//   evt_ready        consumer accepts the head entry
//   evt_data         head event {extended, break, code[7:0]}
//   fifo_level       current FIFO occupancy
//   overflow_sticky  an event was dropped on a full FIFO
//   frame_err_count  saturating count of bad frames
//   clr_errors       one-cycle pulse clearing the two error indications
module ps2_keyboard_rx_fifo #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int TIMEOUT_US    = 200,
  parameter int FIFO_DEPTH    = 8,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2_clk_in,
  input  logic                        ps2_data_in,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [9:0]                  evt_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow_sticky,
  output logic [7:0]                  frame_err_count,
  input  logic                        clr_errors
);
  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // ---------------- synchronisers ([0] newest, [2] oldest) ----------------
  logic [2:0] clk_sync_q, data_sync_q;
  logic       fall, din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[1:0], ps2_data_in};
    end
  end

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign din  = data_sync_q[1];

  // ---------------- frame FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic          abort_q, abort_d;
  logic          stop_good;

`ifdef PS2_PARITY_CHECK_EN
  assign stop_good = din & (^{shreg_q, parity_q});
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign stop_good     = din;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    abort_d     = 1'b0;
    to_cnt_d    = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (fall && !din) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA: if (fall) begin
        shreg_d   = {din, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        parity_d = din;
        state_d  = S_STOP;
      end
      S_STOP: if (fall) begin
        state_d = S_IDLE;
        if (stop_good) frame_ok_d  = 1'b1;
        else           frame_err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A fall in the same cycle restarts the count, so it takes precedence.
    if (state_q != S_IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      abort_d     = 1'b1;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      abort_q     <= abort_d;
    end
  end

  // ---------------- decoder + repeat filter ----------------
  // shreg_q is not shifted again until the next frame's data bits, so it
  // still holds the received byte while frame_ok_q is high.
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       lm_valid_q, lm_valid_d;
  logic [8:0] last_make_q, last_make_d;
  logic       push_q, push_d;
  logic [9:0] push_data_q, push_data_d;

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    lm_valid_d  = lm_valid_q;
    last_make_d = last_make_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (abort_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frame_ok_q) begin
      case (shreg_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'h00, 8'hFF: begin end
        default: begin
          ext_d       = 1'b0;
          brk_d       = 1'b0;
          push_data_d = {ext_q, brk_q, shreg_q};
          if (FILTER_REPEAT == 0) begin
            push_d = 1'b1;
          end else if (brk_q) begin
            push_d = 1'b1;
            if ({ext_q, shreg_q} == last_make_q) lm_valid_d = 1'b0;
          end else if (!(lm_valid_q && {ext_q, shreg_q} == last_make_q)) begin
            push_d      = 1'b1;
            last_make_d = {ext_q, shreg_q};
            lm_valid_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      lm_valid_q  <= 1'b0;
      last_make_q <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      lm_valid_q  <= lm_valid_d;
      last_make_q <= last_make_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // ---------------- FIFO and error reporting ----------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full, pop, do_push, drop;
  logic          sticky_q, sticky_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = evt_valid & evt_ready;
  assign do_push = push_q & (~full | pop);
  assign drop    = push_q & full & ~pop;

  always_comb begin
    level_d = level_q;
    case ({do_push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Clear first, then apply this cycle's error/drop.
    sticky_d  = clr_errors ? 1'b0 : sticky_q;
    err_cnt_d = clr_errors ? 8'd0 : err_cnt_q;
    if (drop) sticky_d = 1'b1;
    if (frame_err_q && err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q   <= level_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign evt_valid       = (level_q != '0);
  assign evt_data        = mem_q[rd_ptr_q];
  assign fifo_level      = level_q;
  assign overflow_sticky = sticky_q;
  assign frame_err_count = err_cnt_q;

endmodule

// File: doc/ps2_keyboard_rx_fifo.md
# ps2_keyboard_rx_fifo

- Parametrised PS/2 keyboard receiver for the game input path.
- Performs a full frame check on each PS/2 frame: start, 8 data bits LSB first, odd parity, stop.
- Applies an idle timeout to abort stalled frames.
- Decodes E0/F0 prefixes into 10-bit key events and can optionally suppress typematic repeats.
- Queues events in a FIFO that the downstream input handler drains with a valid/ready handshake.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TIMEOUT_US`, 200, PS/2 inter-edge timeout. `TIMEOUT_CYCLES = CLK_HZ/1_000_000*TIMEOUT_US`.
- `FIFO_DEPTH`, 8, event FIFO entries. Must be a power of two, ≥2.
- `FILTER_REPEAT`, 1, 1 = drop repeated make codes of a held key; 0 = pass all.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk_in`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data_in`  in  1  raw PS/2 data, asynchronous.
- `evt_valid`  out  1  FIFO non-empty; `evt_data` valid.
- `evt_ready`  in  1  consumer accepts the head entry.
- `evt_data`  out  10  head event `{extended, break, code[7:0]}`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow_sticky`  out  1  set when an event was dropped on a full FIFO.
- `frame_err_count`  out  8  saturating count of bad frames (parity, stop, timeout).
- `clr_errors`  in  1  one-cycle pulse; clears `frame_err_count` and `overflow_sticky`.

## Operation
- **Synchronisers:** `ps2_clk_in` and `ps2_data_in` each pass through 3 flops, reset to 1. The falling-edge pulse `fall` is asserted when the oldest clock flop is 1 and the middle flop is 0. Data is sampled from the middle data flop in the same cycle.
- **Frame FSM:** states IDLE, DATA, PARITY, STOP.
  - IDLE: `fall` with data 0 moves to DATA and clears `bit_cnt`. `fall` with data 1 is ignored.
  - DATA: on each `fall`, `shreg <= {d, shreg[7:1]}`. After the 8th bit, move to PARITY.
  - PARITY: `fall` latches the parity bit and moves to STOP.
  - STOP: `fall` checks the frame. If data is 1 and `^{shreg,parity}` is 1, pulse `frame_ok` with `shreg`. Otherwise pulse `frame_err`. Return to IDLE either way.
- **Timeout:** the counter clears on every `fall` and while in IDLE. If it reaches `TIMEOUT_CYCLES` outside IDLE, the FSM returns to IDLE, pulses `frame_err`, and clears the pending prefix flags.
- **Decoder:** acts on `frame_ok`.
  - `E0` sets `ext_pend`; `F0` sets `brk_pend`. Both flags persist, so `E0 F0 xx` yields an extended break.
  - Bytes `00` and `FF` are discarded and do not touch the flags.
  - Any other byte emits `{ext_pend, brk_pend, byte}` and clears both flags.
- **Repeat filter** (when `FILTER_REPEAT`=1): tracks the last make code (`last_make[8:0]`, `lm_valid`).
  - Make equal to `last_make` while `lm_valid`: suppressed.
  - Other make: emitted; `last_make` updated and `lm_valid` set.
  - Break: always emitted. It clears `lm_valid` if `{ext,code}` equals `last_make`.
- **FIFO:**
  - Push on emit. Pop on `evt_valid & evt_ready`.
  - Push when full without a same-cycle pop: event dropped, `overflow_sticky` set.
  - Push when full with a same-cycle pop: both happen and the level is unchanged.
  - `evt_data` holds stable while `evt_valid & ~evt_ready`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Error counter:** `frame_err_count` increments per `frame_err` and saturates at 255.
  - `clr_errors` zeroes the counter and the sticky flag.
  - If `clr_errors` coincides with an error, the result is count 1 (clear, then increment). A coincident overflow leaves the sticky flag set.

## Timing
- **Reset values:**
  - `evt_valid`=0, `evt_data`=0, `fifo_level`=0, `overflow_sticky`=0, `frame_err_count`=0.
  - FSM in IDLE; flags, `lm_valid` and pointers cleared.
- **Pin to `fall`:** 2–3 `clk` after the `ps2_clk_in` falling edge.
- **Pipeline:** with `fall` for the stop bit in cycle N:
  - `frame_ok` or `frame_err` in N+1.
  - Decoder push in N+2.
  - `evt_valid` rises in N+3 if the FIFO was empty.
- **Pop:** `evt_valid` falls the cycle after the last entry is popped. The next entry appears on `evt_data` the cycle after a pop.
- **Reset mid-frame:** the partial frame is lost, and no error is counted for it.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: parity mismatch yields `frame_err` and the byte is dropped.
- Not defined: the parity bit is captured but ignored; only the stop bit and timeout produce `frame_err`.

## Test plan
- **Make code:** frame `1D`, good parity → event `0x01D` on `evt_data`, `evt_valid` at N+3, `fifo_level`=1.
- **Extended break:** `E0 F0 75` → single event `0x375`; prefixes produce no events.
- **Repeat filter:** `FILTER_REPEAT`=1, stream `75 75 75 F0 75 75` → events `0x075, 0x175, 0x075`. With `FILTER_REPEAT`=0 → six bytes yield 5 events.
- **Parity error and timeout:** bad-parity frame of `29` (macro defined) → no event, `frame_err_count`=1. Stop clocks after 4 bits for more than 200 µs → count 2, FSM in IDLE, next frame decodes correctly.
- **Overflow:** `FIFO_DEPTH`=4, `evt_ready`=0, send 5 makes → `fifo_level`=4, `overflow_sticky`=1, first 4 events retained in order. `clr_errors` → sticky 0.
- **Reset mid-frame:** assert `reset` during DATA, release, send `6B` → event `0x06B`, `frame_err_count`=0.
